stochastic_bitstream_decoder: RTL and testbench
===============================================

STOCHASTIC_BITSTREAM_DECODER -- requirements
Module: stochastic_bitstream_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: result width; one window = 2^WIDTH accepted samples.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ena  input  1  design enable; low freezes all state and outputs.
REQ-005 SHALL have port start  input  1  request to begin a new counting window.
REQ-006 SHALL have port bit_in  input  1  stochastic bitstream sample from the multiplier stage.
REQ-007 SHALL have port bit_valid  input  1  qualifies bit_in; sample accepted when ena & bit_valid in COUNT.
REQ-008 SHALL have port result_ready  input  1  consumer accepts result.
REQ-009 SHALL have port result  output  WIDTH  decoded binary value (count of ones in window, saturated).
REQ-010 SHALL have port result_valid  output  1  result held and valid.
REQ-011 SHALL have port sat  output  1  window contained all ones; result clamped.
REQ-012 SHALL have port busy  output  1  high while in COUNT.

Function
REQ-013 SHALL implement FSM states IDLE, COUNT, HOLD.
REQ-014 IDLE: start & ena -> COUNT next cycle; sample counter and ones counter cleared on that transition.
REQ-015 COUNT: per accepted sample, sample counter +1 (WIDTH bits), ones counter +bit_in (WIDTH+1 bits).
REQ-016 COUNT: cycles with bit_valid=0 or ena=0 SHALL leave both counters unchanged.
REQ-017 COUNT -> HOLD on the cycle the 2^WIDTH-th sample is accepted; that sample SHALL be included.
REQ-018 On entry to HOLD, result = min(ones, 2^WIDTH-1), sat = (ones == 2^WIDTH); result_valid=1 the cycle after the last sample.
REQ-019 HOLD: result, sat, result_valid SHALL stay stable until result_ready & ena sampled high.
REQ-020 HOLD with result_ready & ena & start in the same cycle -> COUNT directly with counters cleared (back-to-back windows).
REQ-021 HOLD with result_ready & ena, start low -> IDLE; result_valid deasserts next cycle; result and sat hold last value.
REQ-022 start SHALL be ignored in COUNT; result_ready SHALL be ignored outside HOLD.
REQ-023 busy SHALL be 1 exactly when state is COUNT.
REQ-024 ena=0 in any state: no transitions, no counter updates, outputs unchanged.

Reset
REQ-025 rst_n low at a clock edge SHALL force IDLE, clear both counters, result=0, sat=0, result_valid=0, busy=0.
REQ-026 Reset mid-window SHALL discard the partial count; no result_valid pulse follows.
REQ-027 rst_n SHALL take priority over ena, start and result_ready.

Structure
REQ-028 Shared package stochastic_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-029 One sub-module sc_window_counter SHALL hold the sample and ones counters, with clear/accept inputs and terminal-count output; FSM and output registers stay in the top.

Verification
REQ-030 WIDTH=8, start, bit_in=1 every cycle, bit_valid=1 -> after 256 samples result=255, sat=1, result_valid next cycle.
REQ-031 bit_in=0 constant -> result=0, sat=0; alternating 1,0 -> result=128, sat=0.
REQ-032 bit_valid toggling every cycle, bit_in=1 -> COUNT lasts 512 cycles, busy high throughout, result=255, sat=1.
REQ-033 rst_n low after 100 samples -> IDLE next cycle, all outputs 0, no result_valid until a new full window.
REQ-034 HOLD with result_ready=1 and start=1 same cycle -> busy=1 next cycle, second window of alternating bits gives 128.
REQ-035 ena=0 for 20 cycles mid-window -> counters frozen; final result equals the ena=1-only reference count.

Source files
------------

// File: rtl/stochastic_pkg.sv
// Shared definitions for the stochastic bitstream decoder: FSM states and default width.
package stochastic_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sc_window_counter.sv
// Sample and ones counters for one decoding window; flags the final sample of the window.
module sc_window_counter
    import stochastic_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           accept,
    input  logic           bit_in,
    output logic           term,
    output logic [WIDTH:0] ones_total
);

    logic [WIDTH-1:0] samples;
    logic [WIDTH:0]   ones;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            samples <= '0;
            ones    <= '0;
        end else if (accept) begin
            samples <= samples + 1'b1;
            ones    <= ones + (WIDTH+1)'(bit_in);
        end
    end

    // Count including the sample being accepted this cycle, so the last sample lands in the result.
    assign term       = accept && (samples == '1);
    assign ones_total = ones + (WIDTH+1)'(bit_in);

endmodule

// File: rtl/stochastic_bitstream_decoder.sv
// Converts a stochastic bitstream into a binary value by counting ones over 2^WIDTH samples.
module stochastic_bitstream_decoder
    import stochastic_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             sat,
    output logic             busy
);

    state_t         state;
    logic           clear;
    logic           accept;
    logic           term;
    logic [WIDTH:0] ones_total;

    assign clear  = ena && start &&
                    ((state == ST_IDLE) || ((state == ST_HOLD) && result_ready));
    assign accept = ena && bit_valid && (state == ST_COUNT);

    sc_window_counter #(.WIDTH(WIDTH)) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .accept     (accept),
        .bit_in     (bit_in),
        .term       (term),
        .ones_total (ones_total)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            result       <= '0;
            sat          <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_COUNT;
                        busy  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (term) begin
                        state        <= ST_HOLD;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        // Only an all-ones window reaches 2^WIDTH; clamp it to the top code.
                        sat          <= ones_total[WIDTH];
                        result       <= ones_total[WIDTH] ? '1 : ones_total[WIDTH-1:0];
                    end
                end
                ST_HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (start) begin
                            state <= ST_COUNT;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stochastic_bitstream_decoder.sv
// Table-driven, scoreboarded bench for stochastic_bitstream_decoder with WIDTH=8.
module tb_stochastic_bitstream_decoder;

    localparam int W = 8;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n, ena, start, bit_in, bit_valid, result_ready;
    logic [W-1:0] result;
    logic         result_valid, sat, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int res;
        int sat;
    } exp_t;
    exp_t sb[$];

    // mode: 0 all ones, 1 all zeros, 2 alternating, 3 valid toggling, 4 ena gap, 5 random
    typedef struct {
        string name;
        int    mode;
        int    exp_res;
        int    exp_sat;
        int    exp_cycles;
        bit    use_model;
    } vec_t;
    vec_t vecs[6];

    stochastic_bitstream_decoder #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .start        (start),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_valid (result_valid),
        .sat          (sat),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_window();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int mode, output int cycles, output int ones, output int busy_bad);
        int n   = 0;
        int gap = 0;
        int b;
        int v;
        int e;
        cycles   = 0;
        ones     = 0;
        busy_bad = 0;
        while (n < N && cycles < 4000) begin
            e = 1; v = 1; b = 1;
            case (mode)
                0: b = 1;
                1: b = 0;
                2: b = (n % 2 == 0) ? 1 : 0;
                3: begin v = cycles % 2; b = 1; end
                4: begin
                    if (n == 100 && gap < 20) begin e = 0; gap++; b = 1; end
                    else b = (n % 2 == 0) ? 1 : 0;
                end
                default: b = int'($urandom_range(0, 1));
            endcase
            ena = e[0]; bit_valid = v[0]; bit_in = b[0];
            if (e == 1 && v == 1) begin
                n++;
                ones += b;
            end
            tick();
            cycles++;
            if (n < N && busy !== 1'b1) busy_bad++;
        end
        ena = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
        if (cycles >= 4000) chk("feed_timeout", cycles, 0);
    endtask

    task automatic wait_and_compare(input string name);
        exp_t e;
        int   k = 0;
        while (result_valid !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk({name, "_valid"}, int'(result_valid), 1);
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({name, "_result"}, int'(result), e.res);
            chk({name, "_sat"}, int'(sat), e.sat);
        end
    endtask

    initial begin
        int cyc, ones, bb;
        int hold_res;
        exp_t e;

        vecs[0] = '{"all_ones",   0, 255, 1, 256, 0};
        vecs[1] = '{"all_zeros",  1,   0, 0, 256, 0};
        vecs[2] = '{"alternate",  2, 128, 0, 256, 0};
        vecs[3] = '{"valid_tog",  3, 255, 1, 512, 0};
        vecs[4] = '{"ena_gap",    4, 128, 0, 276, 0};
        vecs[5] = '{"random",     5,   0, 0, 256, 1};

        rst_n = 1'b0; ena = 1'b1; start = 1'b0; bit_in = 1'b0;
        bit_valid = 1'b0; result_ready = 1'b0;
        tick(); tick();
        chk("rst_result", int'(result), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            start_window();
            chk({vecs[i].name, "_busy_start"}, int'(busy), 1);
            feed(vecs[i].mode, cyc, ones, bb);
            chk({vecs[i].name, "_cycles"}, cyc, vecs[i].exp_cycles);
            chk({vecs[i].name, "_busy_through"}, bb, 0);
            chk({vecs[i].name, "_busy_end"}, int'(busy), 0);
            if (vecs[i].use_model) begin
                e.res = (ones >= N) ? N - 1 : ones;
                e.sat = (ones == N) ? 1 : 0;
            end else begin
                e.res = vecs[i].exp_res;
                e.sat = vecs[i].exp_sat;
            end
            sb.push_back(e);
            wait_and_compare(vecs[i].name);
            hold_res = int'(result);
            // ena low with ready high: HOLD must not be released
            ena = 1'b0; result_ready = 1'b1;
            tick(); tick();
            chk({vecs[i].name, "_hold_ena0"}, int'(result_valid), 1);
            ena = 1'b1;
            tick();
            result_ready = 1'b0;
            chk({vecs[i].name, "_release_valid"}, int'(result_valid), 0);
            chk({vecs[i].name, "_release_keep"}, int'(result), hold_res);
            tick();
        end

        // Back-to-back windows: ready and start together in HOLD
        start_window();
        feed(0, cyc, ones, bb);
        sb.push_back('{255, 1});
        wait_and_compare("b2b_first");
        result_ready = 1'b1; start = 1'b1;
        tick();
        result_ready = 1'b0; start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_valid_drop", int'(result_valid), 0);
        feed(2, cyc, ones, bb);
        sb.push_back('{128, 0});
        wait_and_compare("b2b_second");
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;

        // Reset mid-window discards the partial count
        start_window();
        for (int k = 0; k < 100; k++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(result_valid), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_sat", int'(sat), 0);
        bb = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (result_valid !== 1'b0 || busy !== 1'b0) bb++;
        end
        bit_valid = 1'b0;
        chk("midrst_no_pulse", bb, 0);
        start_window();
        feed(1, cyc, ones, bb);
        sb.push_back('{0, 0});
        wait_and_compare("after_rst");

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
